// File: rtl/matrix_mul_pkg.sv
// Shared types and helpers for the sequential matrix multiplier.
// Saturation bounds are only consumed when MATRIX_MUL_SAT_EN is defined.
package matrix_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mm_state_t;

    function automatic int acc_w(input int bits, input int width);
        return 2 * bits + $clog2(width) + 1;
    endfunction

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic longint sat_smax(input int bits);
        return (64'sd1 <<< (2 * bits - 1)) - 64'sd1;
    endfunction

    function automatic longint sat_smin(input int bits);
        return -(64'sd1 <<< (2 * bits - 1));
    endfunction

    function automatic longint sat_umax(input int bits);
        return (64'sd1 <<< (2 * bits)) - 64'sd1;
    endfunction

endpackage

// File: rtl/matrix_mul_seq_mac.sv
// Shared extend/multiply/accumulate datapath with result formatting.
// MATRIX_MUL_SAT_EN selects saturating output instead of wrap-around truncation.
module matrix_mac_pe
    import matrix_mul_pkg::*;
#(
    parameter int BITS  = 8,
    parameter int WIDTH = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              mac_en,
    input  logic              last,
    input  logic              is_signed,
    input  logic [BITS-1:0]   a,
    input  logic [BITS-1:0]   b,
    output logic [2*BITS-1:0] res
`ifdef MATRIX_MUL_SAT_EN
    ,
    output logic              clamp
`endif
);

    localparam int ACC_W = acc_w(BITS, WIDTH);

    logic [ACC_W-1:0] acc_r;
    logic [ACC_W-1:0] ext_a_s;
    logic [ACC_W-1:0] ext_b_s;
    logic [ACC_W-1:0] prod_s;
    logic [ACC_W-1:0] sum_s;

    // Low ACC_W bits of the product are exact in both modes, so one unsigned multiply serves both.
    assign ext_a_s = is_signed ? {{(ACC_W-BITS){a[BITS-1]}}, a} : {{(ACC_W-BITS){1'b0}}, a};
    assign ext_b_s = is_signed ? {{(ACC_W-BITS){b[BITS-1]}}, b} : {{(ACC_W-BITS){1'b0}}, b};
    assign prod_s  = ext_a_s * ext_b_s;
    assign sum_s   = acc_r + prod_s;

    // Accumulator: restarts on job start and after each finished element.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_r <= '0;
        end else if (clr) begin
            acc_r <= '0;
        end else if (mac_en) begin
            acc_r <= last ? '0 : sum_s;
        end else begin
            acc_r <= acc_r;
        end
    end

`ifdef MATRIX_MUL_SAT_EN
    localparam longint SMAX_L = sat_smax(BITS);
    localparam longint SMIN_L = sat_smin(BITS);
    localparam longint UMAX_L = sat_umax(BITS);
    localparam logic [ACC_W-1:0] SMAX_C = SMAX_L[ACC_W-1:0];
    localparam logic [ACC_W-1:0] SMIN_C = SMIN_L[ACC_W-1:0];
    localparam logic [ACC_W-1:0] UMAX_C = UMAX_L[ACC_W-1:0];

    // Clamp to the result range; unsigned sums never reach the accumulator sign bit.
    always_comb begin
        res   = sum_s[2*BITS-1:0];
        clamp = 1'b0;
        if (is_signed) begin
            if ($signed(sum_s) > $signed(SMAX_C)) begin
                res   = SMAX_C[2*BITS-1:0];
                clamp = 1'b1;
            end else if ($signed(sum_s) < $signed(SMIN_C)) begin
                res   = SMIN_C[2*BITS-1:0];
                clamp = 1'b1;
            end else begin
                res   = sum_s[2*BITS-1:0];
                clamp = 1'b0;
            end
        end else begin
            if ($signed(sum_s) > $signed(UMAX_C)) begin
                res   = UMAX_C[2*BITS-1:0];
                clamp = 1'b1;
            end else begin
                res   = sum_s[2*BITS-1:0];
                clamp = 1'b0;
            end
        end
    end
`else
    assign res = sum_s[2*BITS-1:0];
`endif

endmodule

// File: rtl/matrix_mul_seq.sv
// Sequential matrix multiplier O = A x B using one shared MAC; start/busy/done handshake.
// Define MATRIX_MUL_SAT_EN for saturating results and the sticky o_sat flag.
module matrix_mul_seq
    import matrix_mul_pkg::*;
#(
    parameter int BITS     = 8,
    parameter int WIDTH    = 3,
    parameter int HEIGHT_A = 2,
    parameter int WIDTH_B  = 3
) (
    input  logic                                           clk,
    input  logic                                           reset,
    input  logic                                           i_start,
    input  logic                                           i_signed,
    input  logic [HEIGHT_A-1:0][WIDTH-1:0][BITS-1:0]       i_array_a,
    input  logic [WIDTH-1:0][WIDTH_B-1:0][BITS-1:0]        i_array_b,
    output logic                                           o_busy,
    output logic                                           o_done,
    output logic [HEIGHT_A-1:0][WIDTH_B-1:0][2*BITS-1:0]   o_array_res
`ifdef MATRIX_MUL_SAT_EN
    ,
    output logic                                           o_sat
`endif
);

    localparam int RW = cnt_w(HEIGHT_A);
    localparam int CW = cnt_w(WIDTH_B);
    localparam int KW = cnt_w(WIDTH);

    mm_state_t                                   state_r;
    logic [RW-1:0]                               r_r;
    logic [CW-1:0]                               c_r;
    logic [KW-1:0]                               k_r;
    logic [HEIGHT_A-1:0][WIDTH-1:0][BITS-1:0]    a_r;
    logic [WIDTH-1:0][WIDTH_B-1:0][BITS-1:0]     b_r;
    logic                                        signed_r;
    logic                                        accept_s;
    logic                                        run_s;
    logic                                        k_last_s;
    logic                                        c_last_s;
    logic                                        r_last_s;
    logic [2*BITS-1:0]                           res_s;
`ifdef MATRIX_MUL_SAT_EN
    logic                                        clamp_s;
`endif

    // DONE doubles as the re-arm slot, so held starts repeat every N+1 cycles.
    assign accept_s = i_start && ((state_r == IDLE) || (state_r == DONE));
    assign run_s    = (state_r == RUN);
    assign k_last_s = (k_r == KW'(WIDTH - 1));
    assign c_last_s = (c_r == CW'(WIDTH_B - 1));
    assign r_last_s = (r_r == RW'(HEIGHT_A - 1));

    matrix_mac_pe #(
        .BITS  (BITS),
        .WIDTH (WIDTH)
    ) u_mac (
        .clk       (clk),
        .reset     (reset),
        .clr       (accept_s),
        .mac_en    (run_s),
        .last      (k_last_s),
        .is_signed (signed_r),
        .a         (a_r[r_r][k_r]),
        .b         (b_r[k_r][c_r]),
        .res       (res_s)
`ifdef MATRIX_MUL_SAT_EN
        ,
        .clamp     (clamp_s)
`endif
    );

    // Job FSM: operand capture, row-major element walk and result writeback.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            r_r         <= '0;
            c_r         <= '0;
            k_r         <= '0;
            a_r         <= '0;
            b_r         <= '0;
            signed_r    <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_array_res <= '0;
`ifdef MATRIX_MUL_SAT_EN
            o_sat       <= 1'b0;
`endif
        end else if (accept_s) begin
            state_r     <= RUN;
            r_r         <= '0;
            c_r         <= '0;
            k_r         <= '0;
            a_r         <= i_array_a;
            b_r         <= i_array_b;
            signed_r    <= i_signed;
            o_busy      <= 1'b1;
            o_done      <= 1'b0;
            o_array_res <= '0;
`ifdef MATRIX_MUL_SAT_EN
            o_sat       <= 1'b0;
`endif
        end else begin
            case (state_r)
                RUN: begin
                    if (k_last_s) begin
                        o_array_res[r_r][c_r] <= res_s;
`ifdef MATRIX_MUL_SAT_EN
                        o_sat <= o_sat | clamp_s;
`endif
                        k_r <= '0;
                        if (c_last_s) begin
                            c_r <= '0;
                            if (r_last_s) begin
                                r_r     <= '0;
                                state_r <= DONE;
                                o_busy  <= 1'b0;
                                o_done  <= 1'b1;
                            end else begin
                                r_r <= r_r + RW'(32'd1);
                            end
                        end else begin
                            c_r <= c_r + CW'(32'd1);
                        end
                    end else begin
                        k_r <= k_r + KW'(32'd1);
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    o_done  <= 1'b0;
                end
                IDLE: begin
                    o_busy <= 1'b0;
                    o_done <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    o_busy  <= 1'b0;
                    o_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_mul_seq.sv
// Scoreboard bench for matrix_mul_seq: stimulus pushes model results, a monitor checks each done.
module tb_matrix_mul_seq;

    localparam int BITS     = 8;
    localparam int WIDTH    = 3;
    localparam int HEIGHT_A = 2;
    localparam int WIDTH_B  = 3;
    localparam int N        = HEIGHT_A * WIDTH_B * WIDTH;

    typedef logic [HEIGHT_A-1:0][WIDTH-1:0][BITS-1:0]     mat_a_t;
    typedef logic [WIDTH-1:0][WIDTH_B-1:0][BITS-1:0]      mat_b_t;
    typedef logic [HEIGHT_A-1:0][WIDTH_B-1:0][2*BITS-1:0] mat_r_t;
    typedef struct {
        mat_r_t res;
        logic   sat;
    } exp_t;

    logic   clk = 1'b0;
    logic   reset;
    logic   i_start;
    logic   i_signed;
    mat_a_t a;
    mat_b_t b;
    logic   o_busy;
    logic   o_done;
    mat_r_t o_res;
`ifdef MATRIX_MUL_SAT_EN
    logic   o_sat;
`endif

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   passes = 0;
    int   done_cnt = 0;
    int   busy_cnt = 0;
    int   cyc = 0;
    int   last_done_cyc = -1;
    logic hold_mode = 1'b0;
    logic done_prev = 1'b0;

    matrix_mul_seq #(
        .BITS(BITS), .WIDTH(WIDTH), .HEIGHT_A(HEIGHT_A), .WIDTH_B(WIDTH_B)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_start     (i_start),
        .i_signed    (i_signed),
        .i_array_a   (a),
        .i_array_b   (b),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_array_res (o_res)
`ifdef MATRIX_MUL_SAT_EN
        ,
        .o_sat       (o_sat)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: textbook matrix product on integers, then wrap or clamp to 2*BITS.
    function automatic exp_t model(input mat_a_t ma, input mat_b_t mb, input logic sgn);
        exp_t   e;
        longint s, x, y;
`ifdef MATRIX_MUL_SAT_EN
        longint lo, hi;
        lo = sgn ? -(64'sd1 <<< (2*BITS-1)) : 64'sd0;
        hi = sgn ? (64'sd1 <<< (2*BITS-1)) - 64'sd1 : (64'sd1 <<< (2*BITS)) - 64'sd1;
`endif
        e.sat = 1'b0;
        for (int r = 0; r < HEIGHT_A; r++) begin
            for (int c = 0; c < WIDTH_B; c++) begin
                s = 0;
                for (int k = 0; k < WIDTH; k++) begin
                    x = sgn ? longint'($signed(ma[r][k])) : longint'(ma[r][k]);
                    y = sgn ? longint'($signed(mb[k][c])) : longint'(mb[k][c]);
                    s = s + x * y;
                end
`ifdef MATRIX_MUL_SAT_EN
                if (s > hi) begin s = hi; e.sat = 1'b1; end
                else if (s < lo) begin s = lo; e.sat = 1'b1; end
`endif
                e.res[r][c] = s[2*BITS-1:0];
            end
        end
        return e;
    endfunction

    function automatic logic [BITS-1:0] rand_elem();
        case ($urandom_range(0, 5))
            0: return 8'h00;
            1: return 8'h7F;
            2: return 8'h80;
            3: return 8'hFF;
            default: return BITS'($urandom());
        endcase
    endfunction

    function automatic mat_a_t rand_a();
        mat_a_t m;
        for (int r = 0; r < HEIGHT_A; r++)
            for (int k = 0; k < WIDTH; k++) m[r][k] = rand_elem();
        return m;
    endfunction

    function automatic mat_b_t rand_b();
        mat_b_t m;
        for (int k = 0; k < WIDTH; k++)
            for (int c = 0; c < WIDTH_B; c++) m[k][c] = rand_elem();
        return m;
    endfunction

    // Monitor: pops the scoreboard on every done pulse.
    always @(negedge clk) begin
        if (reset) begin
            busy_cnt  = 0;
            done_prev = 1'b0;
        end else begin
            if (done_prev) check("done_single_pulse", o_done, 1'b0);
            if (o_busy) busy_cnt++;
            if (o_done) begin
                if (exp_q.size() == 0) begin
                    check("done_with_no_job", o_done, 1'b0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("result", o_res, mon_e.res);
`ifdef MATRIX_MUL_SAT_EN
                    check("sat_flag", o_sat, mon_e.sat);
`endif
                    check("busy_cycles", busy_cnt, N);
                    check("busy_low_in_done", o_busy, 1'b0);
                    if (hold_mode && last_done_cyc >= 0)
                        check("job_period", cyc - last_done_cyc, N + 1);
                end
                last_done_cyc = hold_mode ? cyc : -1;
                busy_cnt = 0;
                done_cnt++;
            end
            done_prev = o_done;
        end
    end

    task automatic wait_done(input int target, input logic scramble);
        for (int i = 0; i < 8 * N; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt >= target) break;
            if (scramble) begin
                a = rand_a();
                b = rand_b();
                i_signed = 1'($urandom_range(0, 1));
                i_start  = ($urandom_range(0, 3) == 0);
            end
        end
        i_start = 1'b0;
        check("done_within_budget", done_cnt >= target, 1'b1);
    endtask

    task automatic run_job_exp(input mat_a_t ma, input mat_b_t mb, input logic sgn, input exp_t e);
        int target;
        @(negedge clk);
        a = ma; b = mb; i_signed = sgn; i_start = 1'b1;
        exp_q.push_back(e);
        target = done_cnt + 1;
        @(negedge clk);
        i_start = 1'b0;
        wait_done(target, 1'b1);
    endtask

    task automatic run_job(input mat_a_t ma, input mat_b_t mb, input logic sgn);
        run_job_exp(ma, mb, sgn, model(ma, mb, sgn));
    endtask

    mat_a_t a1, a_sg, a7f, aff, ha;
    mat_b_t b1, b7f, bff, hb;
    exp_t   e1;
    logic   hs;
    int     target;

    initial begin
        reset = 1'b1; i_start = 1'b0; i_signed = 1'b0; a = '0; b = '0;
        a1   = {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3};
        b1   = {8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        a_sg = {8'h00, 8'hFB, 8'h00, 8'h00, 8'h00, 8'h01};
        a7f  = {6{8'h7F}};
        b7f  = {9{8'h7F}};
        aff  = {6{8'hFF}};
        bff  = {9{8'hFF}};
        e1.res = {16'd132, 16'd111, 16'd90, 16'd78, 16'd66, 16'd54};
        e1.sat = 1'b0;

        repeat (2) @(negedge clk);
        check("reset_busy", o_busy, 1'b0);
        check("reset_done", o_done, 1'b0);
        check("reset_res", o_res, '0);
`ifdef MATRIX_MUL_SAT_EN
        check("reset_sat", o_sat, 1'b0);
`endif
        reset = 1'b0;

        run_job_exp(a1, b1, 1'b0, e1);
        run_job(a_sg, b1, 1'b1);
        run_job(a_sg, b1, 1'b0);
        run_job(a7f, b7f, 1'b1);
        run_job(aff, bff, 1'b0);
        for (int j = 0; j < 8; j++) run_job(rand_a(), rand_b(), 1'($urandom_range(0, 1)));

        // Start held high: three jobs back to back.
        ha = rand_a(); hb = rand_b(); hs = 1'($urandom_range(0, 1));
        @(negedge clk);
        hold_mode = 1'b1;
        a = ha; b = hb; i_signed = hs; i_start = 1'b1;
        repeat (3) exp_q.push_back(model(ha, hb, hs));
        target = done_cnt + 3;
        wait_done(target, 1'b0);
        hold_mode = 1'b0;

        // Reset after the 7th RUN cycle aborts the job.
        @(negedge clk);
        a = a1; b = b1; i_signed = 1'b0; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (7) @(negedge clk);
        check("partial_elem", o_res[0][0], 16'd54);
        #2 reset = 1'b1;
        #1;
        check("abort_busy", o_busy, 1'b0);
        check("abort_done", o_done, 1'b0);
        check("abort_res", o_res, '0);
        @(negedge clk);
        #2 reset = 1'b0;
        run_job_exp(a1, b1, 1'b0, e1);

        repeat (N + 4) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
